parity_gen: RTL and testbench

//   Serial running-parity generator: samples 1-bit stream x on each rising clk edge
//   and flags whether the count of 1s since reset is odd.
//   Two-state Moore FSM, registered output; sits at the tail of a serial link or

---
 rtl/parity_gen.sv | 36 +++
 tb/tb_parity_gen.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/parity_gen.sv
// parity_gen: serial running-parity generator; z flags odd (or, with ODD_PARITY=1, even) count of sampled 1s on x.
//   Ports: x (serial data bit, sampled every rising clk), clk (rising-edge clock),
//          z (registered running parity), rst_n (async active-low reset),
//          ones_cnt (CNT_W-bit count of sampled 1s, only with PARITY_GEN_CNT_EN defined).
//   Optional feature macro: PARITY_GEN_CNT_EN adds the ones counter and its port.
module parity_gen #(
  parameter bit ODD_PARITY = 1'b0,
  parameter int CNT_W = 8
) (
  input  logic x,
  input  logic clk,
  output logic z,
  input  logic rst_n
`ifdef PARITY_GEN_CNT_EN
  ,
  output logic [CNT_W-1:0] ones_cnt
`endif
);
  typedef enum logic {EVEN = 1'b0, ODD = 1'b1} state_t;
  state_t state, state_nxt;
  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("CNT_W must be at least 1");
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= EVEN;
    else state <= state_nxt;
  always_comb state_nxt = x ? (state == ODD ? EVEN : ODD) : state;
  // z decodes only the state flop, so x never reaches z combinationally
  always_comb z = (state == ODD) ^ ODD_PARITY;
`ifdef PARITY_GEN_CNT_EN
  // wraps naturally; its LSB tracks the parity state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ones_cnt <= '0;
    else if (x) ones_cnt <= ones_cnt + CNT_W'(1);
`endif
endmodule

// File: tb/tb_parity_gen.sv
// tb_parity_gen: table-driven check of parity_gen for both ODD_PARITY settings, reset and glitch corners.
module tb_parity_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic x = 1'b0;
  logic z0, z1;
  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 0;
`ifdef PARITY_GEN_CNT_EN
  logic [1:0] cnt0, cnt1;
`endif

  parity_gen #(.ODD_PARITY(1'b0), .CNT_W(2)) dut0 (
    .x(x), .clk(clk), .z(z0), .rst_n(rst_n)
`ifdef PARITY_GEN_CNT_EN
    , .ones_cnt(cnt0)
`endif
  );
  parity_gen #(.ODD_PARITY(1'b1), .CNT_W(2)) dut1 (
    .x(x), .clk(clk), .z(z1), .rst_n(rst_n)
`ifdef PARITY_GEN_CNT_EN
    , .ones_cnt(cnt1)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic x;
    logic z;
  } vec_t;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_z(input string name, input logic exp_z0);
    chk({name, ".z0"}, {7'd0, z0}, {7'd0, exp_z0});
    chk({name, ".z1"}, {7'd0, z1}, {7'd0, ~exp_z0});
`ifdef PARITY_GEN_CNT_EN
    chk({name, ".cnt"}, {6'd0, cnt0}, 8'(exp_cnt % 4));
    chk({name, ".cnt_lsb"}, {7'd0, cnt0[0]}, {7'd0, z0});
    chk({name, ".cnt1"}, {6'd0, cnt1}, 8'(exp_cnt % 4));
`endif
  endtask

  task automatic step(input logic b);
    @(negedge clk);
    x = b;
    @(posedge clk);
    if (b) exp_cnt++;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    x = 1'b0;
    rst_n = 1'b0;
    exp_cnt = 0;
    #2;
    rst_n = 1'b1;
  endtask

  vec_t stream[12];
  logic cnt_z[5];
  logic [1:0] cnt_v[5];

  initial begin
    stream = '{'{1'b0, 1'b0}, '{1'b1, 1'b1}, '{1'b1, 1'b0}, '{1'b1, 1'b1},
               '{1'b0, 1'b1}, '{1'b1, 1'b0}, '{1'b1, 1'b1}, '{1'b0, 1'b1},
               '{1'b0, 1'b1}, '{1'b1, 1'b0}, '{1'b1, 1'b1}, '{1'b0, 1'b1}};
    cnt_z = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    cnt_v = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    // reset state before any edge
    #1;
    chk_z("reset", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      chk_z($sformatf("hold%0d", i), 1'b0);
    end
    // main stream
    for (int i = 0; i < 12; i++) begin
      step(stream[i].x);
      chk_z($sformatf("stream%0d", i), stream[i].z);
    end
    // async reset between edges
    do_reset();
    step(1'b1);
    chk_z("pre_rst", 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_cnt = 0;
    #1;
    chk_z("async_rst", 1'b0);
    x = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    exp_cnt++;
    #1;
    chk_z("post_rst", 1'b1);
    // inverted parity: dut1 sees 0,1,1 after x=1,1,0
    do_reset();
    #1;
    chk("odd_rst", {7'd0, z1}, 8'd1);
    step(1'b1);
    chk("odd_v0", {7'd0, z1}, 8'd0);
    step(1'b1);
    chk("odd_v1", {7'd0, z1}, 8'd1);
    step(1'b0);
    chk("odd_v2", {7'd0, z1}, 8'd1);
    // five ones: counter wraps at 4 with CNT_W=2
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1);
      chk($sformatf("five%0d.z", i), {7'd0, z0}, {7'd0, cnt_z[i]});
`ifdef PARITY_GEN_CNT_EN
      chk($sformatf("five%0d.cnt", i), {6'd0, cnt0}, {6'd0, cnt_v[i]});
      chk($sformatf("five%0d.lsb", i), {7'd0, cnt0[0]}, {7'd0, z0});
`endif
    end
    // glitches between edges are ignored
    do_reset();
    step(1'b1);
    @(negedge clk);
    x = 1'b1;
    #1 x = 1'b0;
    #1 x = 1'b1;
    #1;
    chk_z("glitch_mid", 1'b1);
    x = 1'b0;
    @(posedge clk);
    #1;
    chk_z("glitch_edge", 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
